// File: rtl/stk_mctx_if.sv
// Command/response bundle for the multi-context stack engine.
// The master side issues per-context commands; the slave side grants them and returns responses and occupancy.
interface stk_mctx_if #(
  parameter int CTX_N = 4,
  parameter int DEPTH = 64,
  parameter int W     = 128
);
  localparam int CTX_W = $clog2(CTX_N);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CTX_N-1:0]            cmd_vld;
  logic [CTX_N-1:0][1:0]       cmd_op;
  logic [CTX_N-1:0][W-1:0]     cmd_dat;
  logic [CTX_N-1:0]            cmd_ack;
  logic                        rsp_vld;
  logic [CTX_W-1:0]            rsp_ctx;
  logic [1:0]                  rsp_op;
  logic                        rsp_err;
  logic [W-1:0]                rsp_dat;
  logic [CTX_N-1:0][CNT_W-1:0] ctx_cnt;
  logic [CNT_W-1:0]            free_cnt;
  logic                        busy;

  modport master (
    output cmd_vld, cmd_op, cmd_dat,
    input  cmd_ack, rsp_vld, rsp_ctx, rsp_op, rsp_err, rsp_dat, ctx_cnt, free_cnt, busy
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_dat,
    output cmd_ack, rsp_vld, rsp_ctx, rsp_op, rsp_err, rsp_dat, ctx_cnt, free_cnt, busy
  );
endinterface

// File: rtl/stk_mctx_pipe.sv
// CTX_N LIFO contexts sharing one linked pool of DEPTH entries, with a linked free list,
// one-cycle CLEAR splicing, round-robin command arbitration and a registered response.
module stk_mctx_pipe #(
  parameter int CTX_N = 4,
  parameter int DEPTH = 64,
  parameter int W     = 128
) (
  input logic         clk,
  input logic         arst,
  stk_mctx_if.slave   bus
);
  localparam int CTX_W = $clog2(CTX_N);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] init_idx;

  logic [W-1:0]     data_mem [DEPTH];
  logic [PTR_W-1:0] next_mem [DEPTH];

  logic [PTR_W-1:0] head [CTX_N];
  logic [PTR_W-1:0] tail [CTX_N];
  logic [CNT_W-1:0] cnt  [CTX_N];
  logic [PTR_W-1:0] free_head;
  logic [CNT_W-1:0] free_cnt;
  logic [CTX_W-1:0] rr;

  logic             grant_vld;
  logic [CTX_W-1:0] grant_ctx, arb_idx, rr_nxt;
  logic [1:0]       gnt_op;
  logic [W-1:0]     gnt_dat;
  logic [PTR_W-1:0] gnt_head, gnt_tail;
  logic [CNT_W-1:0] gnt_cnt;
  logic             do_push, do_pop, do_clr, cmd_err;

  logic             vld_p1;
  logic [CTX_W-1:0] ctx_p1;
  logic [1:0]       op_p1;
  logic             err_p1;
  logic [W-1:0]     dat_p1;

  // ---- p0: arbitration and command decode ----
  always_comb begin
    grant_vld = 1'b0;
    grant_ctx = '0;
    arb_idx   = '0;
    for (int k = 0; k < CTX_N; k++) begin
      arb_idx = CTX_W'((int'(rr) + k) % CTX_N);
      if (!grant_vld && bus.cmd_vld[arb_idx]) begin
        grant_vld = 1'b1;
        grant_ctx = arb_idx;
      end
    end
    if (state != ST_RUN) grant_vld = 1'b0;
  end

  assign rr_nxt   = (grant_ctx == CTX_W'(CTX_N - 1)) ? '0 : grant_ctx + 1'b1;
  assign gnt_op   = bus.cmd_op[grant_ctx];
  assign gnt_dat  = bus.cmd_dat[grant_ctx];
  assign gnt_head = head[grant_ctx];
  assign gnt_tail = tail[grant_ctx];
  assign gnt_cnt  = cnt[grant_ctx];

  assign do_push = grant_vld && (gnt_op == OP_PUSH) && (free_cnt != '0);
  assign do_pop  = grant_vld && (gnt_op == OP_POP)  && (gnt_cnt != '0);
  assign do_clr  = grant_vld && (gnt_op == OP_CLR)  && (gnt_cnt != '0);
  assign cmd_err = grant_vld && (((gnt_op == OP_PUSH) && (free_cnt == '0)) ||
                                 ((gnt_op == OP_POP)  && (gnt_cnt == '0)));

  assign bus.cmd_ack = grant_vld ? (CTX_N'(1) << grant_ctx) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_idx == PTR_W'(DEPTH - 1)) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= ST_INIT;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      init_idx  <= '0;
      free_head <= '0;
      free_cnt  <= '0;
      rr        <= '0;
      vld_p1    <= 1'b0;
      ctx_p1    <= '0;
      op_p1     <= '0;
      err_p1    <= 1'b0;
      dat_p1    <= '0;
      for (int c = 0; c < CTX_N; c++) begin
        head[c] <= '0;
        tail[c] <= '0;
        cnt[c]  <= '0;
      end
    end else begin
      vld_p1 <= grant_vld;
      if (grant_vld) begin
        ctx_p1 <= grant_ctx;
        op_p1  <= gnt_op;
        err_p1 <= cmd_err;
        dat_p1 <= do_pop ? data_mem[gnt_head] : '0;
        rr     <= rr_nxt;
      end
      if (state == ST_INIT) begin
        init_idx <= init_idx + 1'b1;
        if (init_idx == PTR_W'(DEPTH - 1)) begin
          free_head <= '0;
          free_cnt  <= CNT_W'(DEPTH);
        end
      end
      if (do_push) begin
        free_head       <= next_mem[free_head];
        head[grant_ctx] <= free_head;
        if (gnt_cnt == '0) tail[grant_ctx] <= free_head;
        cnt[grant_ctx]  <= gnt_cnt + 1'b1;
        free_cnt        <= free_cnt - 1'b1;
      end
      if (do_pop) begin
        head[grant_ctx] <= next_mem[gnt_head];
        free_head       <= gnt_head;
        cnt[grant_ctx]  <= gnt_cnt - 1'b1;
        free_cnt        <= free_cnt + 1'b1;
      end
      // Whole list is spliced ahead of the free list through its tail link.
      if (do_clr) begin
        free_head      <= gnt_head;
        free_cnt       <= free_cnt + gnt_cnt;
        cnt[grant_ctx] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_INIT) next_mem[init_idx] <= init_idx + 1'b1;
    if (do_push) begin
      data_mem[free_head] <= gnt_dat;
      next_mem[free_head] <= gnt_head;
    end
    if (do_pop) next_mem[gnt_head] <= free_head;
    if (do_clr) next_mem[gnt_tail] <= free_head;
  end

  // ---- p1: registered response and status ----
  assign bus.rsp_vld  = vld_p1;
  assign bus.rsp_ctx  = ctx_p1;
  assign bus.rsp_op   = op_p1;
  assign bus.rsp_err  = err_p1;
  assign bus.rsp_dat  = dat_p1;
  assign bus.free_cnt = free_cnt;
  assign bus.busy     = (state == ST_INIT);

  always_comb begin
    for (int c = 0; c < CTX_N; c++) bus.ctx_cnt[c] = cnt[c];
  end
endmodule

// File: tb/tb_stk_mctx_pipe.sv
// Randomized and directed bench for stk_mctx_pipe against a per-context queue model.
module tb_stk_mctx_pipe;
  localparam int CTX_N = 4;
  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int CTX_W = $clog2(CTX_N);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RW    = CTX_W + 2 + 1 + W;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  stk_mctx_if #(.CTX_N(CTX_N), .DEPTH(DEPTH), .W(W)) bus ();
  stk_mctx_pipe #(.CTX_N(CTX_N), .DEPTH(DEPTH), .W(W)) dut (.clk(clk), .arst(arst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] m_q [CTX_N][$];
  int m_rr;

  logic [CTX_N-1:0]            exp_ack, obs_ack;
  logic                        exp_rvld, obs_rvld, obs_rerr;
  logic [RW-1:0]               exp_rsp, obs_rsp;
  logic [W-1:0]                obs_rdat;
  logic [CNT_W-1:0]            exp_free, obs_free;
  logic [CTX_N-1:0][CNT_W-1:0] exp_cnt, obs_cnt;

  function automatic logic [CTX_W-1:0] cx(int i);
    return CTX_W'(i);
  endfunction

  function automatic int model_used();
    int s = 0;
    for (int c = 0; c < CTX_N; c++) s += m_q[cx(c)].size();
    return s;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CTX_N; c++) m_q[cx(c)].delete();
    m_rr = 0;
  endtask

  // Drives one cycle, predicts grant/response from the model, samples the response a cycle later.
  task automatic run_cycle(input logic [CTX_N-1:0] vld, input logic [CTX_N-1:0][1:0] op,
                           input logic [CTX_N-1:0][W-1:0] dat);
    int g, idx;
    logic [CTX_W-1:0] gc;
    logic rerr;
    logic [W-1:0] rdat;
    bus.cmd_vld = vld;
    bus.cmd_op  = op;
    bus.cmd_dat = dat;
    #1 obs_ack = bus.cmd_ack;
    g = -1;
    for (int k = 0; k < CTX_N; k++) begin
      idx = (m_rr + k) % CTX_N;
      if (g < 0 && vld[cx(idx)]) g = idx;
    end
    exp_ack = '0;
    exp_rsp = '0;
    rerr = 1'b0;
    rdat = '0;
    if (g >= 0) begin
      gc = cx(g);
      exp_ack[gc] = 1'b1;
      m_rr = (g + 1) % CTX_N;
      case (op[gc])
        OP_PUSH: if (model_used() == DEPTH) rerr = 1'b1; else m_q[gc].push_back(dat[gc]);
        OP_POP:  if (m_q[gc].size() == 0) rerr = 1'b1; else rdat = m_q[gc].pop_back();
        OP_CLR:  m_q[gc].delete();
        default: ;
      endcase
      exp_rsp = {gc, op[gc], rerr, rdat};
    end
    exp_rvld = (g >= 0);
    @(posedge clk);
    @(negedge clk);
    obs_rvld = bus.rsp_vld;
    obs_rsp  = {bus.rsp_ctx, bus.rsp_op, bus.rsp_err, bus.rsp_dat};
    obs_rerr = bus.rsp_err;
    obs_rdat = bus.rsp_dat;
    obs_free = bus.free_cnt;
    obs_cnt  = bus.ctx_cnt;
    exp_free = CNT_W'(DEPTH - model_used());
    for (int c = 0; c < CTX_N; c++) exp_cnt[cx(c)] = CNT_W'(m_q[cx(c)].size());
    bus.cmd_vld = '0;
  endtask

  // Holds NOP requests on all contexts until busy falls (bounded); reports what it saw.
  task automatic wait_init(output int cyc, output logic ack_in_init, output logic [CTX_N-1:0] first_ack);
    cyc = 0;
    ack_in_init = 1'b0;
    first_ack = '0;
    bus.cmd_vld = '1;
    bus.cmd_op  = '0;
    for (int k = 0; k < 4 * DEPTH + 10; k++) begin
      #1;
      if (!bus.busy) begin
        first_ack = bus.cmd_ack;
        break;
      end
      if (bus.cmd_ack !== '0) ack_in_init = 1'b1;
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    bus.cmd_vld = '0;
  endtask

  task automatic test_reset();
    int cyc;
    logic ain;
    logic [CTX_N-1:0] fa;
    arst = 1'b1;
    bus.cmd_vld = '1;
    bus.cmd_op = '0;
    bus.cmd_dat = '0;
    @(negedge clk);
    #1;
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
    n_chk++; if (bus.cmd_ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus.cmd_ack); end
    n_chk++; if ({bus.rsp_vld, bus.rsp_ctx, bus.rsp_op, bus.rsp_err, bus.rsp_dat} !== '0) begin
      n_fail++; $display("FAIL reset_rsp: got vld=%b dat=%h expected all zero", bus.rsp_vld, bus.rsp_dat); end
    n_chk++; if ({bus.free_cnt, bus.ctx_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got free=%0d cnt=%h expected 0", bus.free_cnt, bus.ctx_cnt); end
    @(negedge clk);
    arst = 1'b0;
    model_reset();
    wait_init(cyc, ain, fa);
    n_chk++; if (cyc !== DEPTH) begin n_fail++; $display("FAIL init_len: got %0d expected %0d", cyc, DEPTH); end
    n_chk++; if (ain !== 1'b0) begin n_fail++; $display("FAIL init_noack: got %b expected 0", ain); end
    n_chk++; if (fa !== 4'b0001) begin n_fail++; $display("FAIL init_first_ack: got %b expected 0001", fa); end
    n_chk++; if (bus.free_cnt !== CNT_W'(DEPTH) || bus.ctx_cnt !== '0) begin
      n_fail++; $display("FAIL init_cnt: got free=%0d cnt=%h expected %0d/0", bus.free_cnt, bus.ctx_cnt, DEPTH); end
  endtask

  task automatic test_lifo();
    logic [CTX_N-1:0][1:0] op;
    logic [CTX_N-1:0][W-1:0] dat;
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < CTX_N; c++) begin op[cx(c)] = 2'($urandom_range(0, 3)); dat[cx(c)] = $urandom; end
      op[1] = (i < 3) ? OP_PUSH : OP_POP;
      dat[1] = W'(32'hA + i);
      run_cycle(4'b0010, op, dat);
      n_chk++; if (obs_ack !== exp_ack) begin n_fail++; $display("FAIL lifo_ack: got %b expected %b", obs_ack, exp_ack); end
      n_chk++; if (obs_rvld !== exp_rvld || obs_rsp !== exp_rsp) begin
        n_fail++; $display("FAIL lifo_rsp: got %b/%h expected %b/%h", obs_rvld, obs_rsp, exp_rvld, exp_rsp); end
      n_chk++; if ({obs_free, obs_cnt} !== {exp_free, exp_cnt}) begin
        n_fail++; $display("FAIL lifo_cnt: got %0d/%h expected %0d/%h", obs_free, obs_cnt, exp_free, exp_cnt); end
      if (i >= 3) begin
        n_chk++; if (obs_rdat !== W'(32'hC - (i - 3)) || obs_rerr !== 1'b0) begin
          n_fail++; $display("FAIL lifo_pop_value: got %h err=%b expected %h", obs_rdat, obs_rerr, 32'hC - (i - 3)); end
      end
    end
    n_chk++; if (obs_free !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL lifo_free: got %0d expected %0d", obs_free, DEPTH); end
  endtask

  task automatic test_round_robin();
    logic [CTX_N-1:0][1:0] op;
    logic [CTX_N-1:0][W-1:0] dat;
    logic [CTX_N-1:0] vld;
    for (int i = 0; i < DEPTH + CTX_N; i++) begin
      for (int c = 0; c < CTX_N; c++) begin
        op[cx(c)] = (i < DEPTH) ? OP_PUSH : OP_CLR;
        dat[cx(c)] = $urandom;
      end
      vld = (i < DEPTH) ? '1 : CTX_N'(1) << (i - DEPTH);
      run_cycle(vld, op, dat);
      n_chk++; if (obs_ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack: got %b expected %b", obs_ack, exp_ack); end
      n_chk++; if (obs_rvld !== exp_rvld || obs_rsp !== exp_rsp) begin
        n_fail++; $display("FAIL rr_rsp: got %b/%h expected %b/%h", obs_rvld, obs_rsp, exp_rvld, exp_rsp); end
      n_chk++; if ({obs_free, obs_cnt} !== {exp_free, exp_cnt}) begin
        n_fail++; $display("FAIL rr_cnt: got %0d/%h expected %0d/%h", obs_free, obs_cnt, exp_free, exp_cnt); end
    end
  endtask

  task automatic test_full_empty();
    logic [CTX_N-1:0][1:0] op;
    logic [CTX_N-1:0][W-1:0] dat;
    logic [CTX_N-1:0] vld;
    for (int i = 0; i < DEPTH + 3; i++) begin
      for (int c = 0; c < CTX_N; c++) begin op[cx(c)] = 2'($urandom_range(0, 3)); dat[cx(c)] = $urandom; end
      if (i <= DEPTH) begin vld = 4'b0001; op[0] = OP_PUSH; end
      else if (i == DEPTH + 1) begin vld = 4'b0100; op[2] = OP_POP; end
      else begin vld = 4'b0001; op[0] = OP_CLR; end
      run_cycle(vld, op, dat);
      n_chk++; if (obs_ack !== exp_ack) begin n_fail++; $display("FAIL full_ack: got %b expected %b", obs_ack, exp_ack); end
      n_chk++; if (obs_rvld !== exp_rvld || obs_rsp !== exp_rsp) begin
        n_fail++; $display("FAIL full_rsp: got %b/%h expected %b/%h", obs_rvld, obs_rsp, exp_rvld, exp_rsp); end
      n_chk++; if ({obs_free, obs_cnt} !== {exp_free, exp_cnt}) begin
        n_fail++; $display("FAIL full_cnt: got %0d/%h expected %0d/%h", obs_free, obs_cnt, exp_free, exp_cnt); end
      if (i <= DEPTH) begin
        n_chk++; if (obs_rerr !== (i == DEPTH)) begin n_fail++; $display("FAIL full_err: got %b at push %0d", obs_rerr, i); end
      end
      if (i == DEPTH) begin
        n_chk++; if (obs_cnt[0] !== CNT_W'(DEPTH) || obs_free !== '0) begin
          n_fail++; $display("FAIL full_unchanged: got %0d/%0d expected %0d/0", obs_cnt[0], obs_free, DEPTH); end
      end
      if (i == DEPTH + 1) begin
        n_chk++; if (obs_rerr !== 1'b1 || obs_rdat !== '0) begin
          n_fail++; $display("FAIL empty_pop: got err=%b dat=%h expected 1/0", obs_rerr, obs_rdat); end
      end
    end
  endtask

  task automatic test_clear();
    logic [CTX_N-1:0][1:0] op;
    logic [CTX_N-1:0][W-1:0] dat;
    int tc[$];
    logic [1:0] to[$];
    for (int i = 0; i < 5; i++) begin tc.push_back(0); to.push_back(OP_PUSH); end
    for (int i = 0; i < 2; i++) begin tc.push_back(3); to.push_back(OP_PUSH); end
    tc.push_back(0); to.push_back(OP_CLR);
    for (int i = 0; i < DEPTH - 2; i++) begin tc.push_back(1); to.push_back(OP_PUSH); end
    for (int i = 0; i < 2; i++) begin tc.push_back(3); to.push_back(OP_POP); end
    tc.push_back(1); to.push_back(OP_CLR);
    foreach (tc[i]) begin
      for (int c = 0; c < CTX_N; c++) begin op[cx(c)] = OP_NOP; dat[cx(c)] = $urandom; end
      op[cx(tc[i])] = to[i];
      run_cycle(CTX_N'(1) << tc[i], op, dat);
      n_chk++; if (obs_ack !== exp_ack) begin n_fail++; $display("FAIL clr_ack: got %b expected %b", obs_ack, exp_ack); end
      n_chk++; if (obs_rvld !== exp_rvld || obs_rsp !== exp_rsp) begin
        n_fail++; $display("FAIL clr_rsp: got %b/%h expected %b/%h", obs_rvld, obs_rsp, exp_rvld, exp_rsp); end
      n_chk++; if ({obs_free, obs_cnt} !== {exp_free, exp_cnt}) begin
        n_fail++; $display("FAIL clr_cnt: got %0d/%h expected %0d/%h", obs_free, obs_cnt, exp_free, exp_cnt); end
      n_chk++; if (obs_rerr !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %b expected 0 at step %0d", obs_rerr, i); end
      if (i == 7) begin
        n_chk++; if (obs_free !== CNT_W'(DEPTH - 2) || obs_cnt[0] !== '0) begin
          n_fail++; $display("FAIL clr_splice: got free=%0d cnt0=%0d expected %0d/0", obs_free, obs_cnt[0], DEPTH - 2); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [CTX_N-1:0][1:0] op;
    logic [CTX_N-1:0][W-1:0] dat;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CTX_N; c++) begin op[cx(c)] = 2'($urandom_range(0, 3)); dat[cx(c)] = $urandom; end
      if (op[0] == OP_CLR && $urandom_range(0, 1) == 0) op[0] = OP_PUSH;
      run_cycle(CTX_N'($urandom_range(0, 15)), op, dat);
      n_chk++; if (obs_ack !== exp_ack) begin n_fail++; $display("FAIL b2b_ack: got %b expected %b", obs_ack, exp_ack); end
      n_chk++; if (obs_rvld !== exp_rvld || (exp_rvld && obs_rsp !== exp_rsp)) begin
        n_fail++; $display("FAIL b2b_rsp: got %b/%h expected %b/%h", obs_rvld, obs_rsp, exp_rvld, exp_rsp); end
      n_chk++; if ({obs_free, obs_cnt} !== {exp_free, exp_cnt}) begin
        n_fail++; $display("FAIL b2b_cnt: got %0d/%h expected %0d/%h", obs_free, obs_cnt, exp_free, exp_cnt); end
    end
  endtask

  task automatic test_reset_midop();
    logic [CTX_N-1:0][1:0] op;
    logic [CTX_N-1:0][W-1:0] dat;
    int cyc;
    logic ain;
    logic [CTX_N-1:0] fa;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < CTX_N; c++) begin op[cx(c)] = OP_PUSH; dat[cx(c)] = $urandom; end
      run_cycle('1, op, dat);
    end
    n_chk++; if (obs_rvld !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got rsp_vld=%b expected 1", obs_rvld); end
    bus.cmd_vld = '1;
    arst = 1'b1;
    #1;
    n_chk++; if (bus.rsp_vld !== 1'b0 || bus.cmd_ack !== '0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_async: got vld=%b ack=%b busy=%b expected 0/0/1", bus.rsp_vld, bus.cmd_ack, bus.busy); end
    n_chk++; if ({bus.free_cnt, bus.ctx_cnt} !== '0) begin
      n_fail++; $display("FAIL midrst_cnt: got free=%0d cnt=%h expected 0", bus.free_cnt, bus.ctx_cnt); end
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
    model_reset();
    wait_init(cyc, ain, fa);
    n_chk++; if (cyc !== DEPTH || ain !== 1'b0 || fa !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_init: got len=%0d ack_in_init=%b first=%b expected %0d/0/0001", cyc, ain, fa, DEPTH); end
    n_chk++; if (bus.free_cnt !== CNT_W'(DEPTH) || bus.ctx_cnt !== '0) begin
      n_fail++; $display("FAIL midrst_free: got %0d/%h expected %0d/0", bus.free_cnt, bus.ctx_cnt, DEPTH); end
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < CTX_N; c++) begin op[cx(c)] = (i < 2) ? OP_PUSH : OP_POP; dat[cx(c)] = $urandom; end
      run_cycle(4'b1001, op, dat);
      n_chk++; if (obs_ack !== exp_ack || obs_rvld !== exp_rvld || obs_rsp !== exp_rsp) begin
        n_fail++; $display("FAIL midrst_after: got %b/%h expected %b/%h", obs_ack, obs_rsp, exp_ack, exp_rsp); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_vld = '0;
    bus.cmd_op  = '0;
    bus.cmd_dat = '0;
    model_reset();
    test_reset();
    test_lifo();
    test_round_robin();
    test_full_empty();
    test_clear();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
